// File: rtl/conv_window_sequencer.sv
// Walks every KxK window of an IMG_H x IMG_W image, issuing pixel/tap addresses with MAC
// enables plus per-window accumulator clear and result strobes. Optional: CONV_SEQ_STALL_EN.
module conv_window_sequencer #(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned K      = 3,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned TAP_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              CLR,
`ifdef CONV_SEQ_STALL_EN
    input  logic              stall,
`endif
    output logic              acc_clr,
    output logic              mac_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_row,
    output logic [ADDR_W-1:0] out_col,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLRA = 3'd1,
        S_MAC  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [TAP_W-1:0]  K_LAST   = TAP_W'(K - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - K);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] row, row_nxt;
    logic [ADDR_W-1:0] col, col_nxt;
    logic [TAP_W-1:0]  kr, kr_nxt;
    logic [TAP_W-1:0]  kc, kc_nxt;
    logic [ADDR_W-1:0] pix_nxt;
    logic [TAP_W-1:0]  tap_nxt;
    logic              frz;
    logic              last_tap;
    logic              last_win;

`ifdef CONV_SEQ_STALL_EN
    assign frz = stall;
`else
    assign frz = 1'b0;
`endif

    assign last_tap = (kr == K_LAST) && (kc == K_LAST);
    assign last_win = (row == ROW_LAST) && (col == COL_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks freeze, freeze outranks normal sequencing
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLRA;
            S_CLRA:  state_nxt = S_MAC;
            S_MAC:   if (last_tap) state_nxt = S_WR;
            S_WR:    state_nxt = last_win ? S_DONE : S_CLRA;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (frz) state_nxt = state;
        if (CLR) state_nxt = S_IDLE;
    end

    // Next counter values and the output values they imply
    always_comb begin
        kr_nxt  = kr;
        kc_nxt  = kc;
        row_nxt = row;
        col_nxt = col;
        if (state == S_MAC) begin
            if (kc == K_LAST) begin
                kc_nxt = '0;
                kr_nxt = (kr == K_LAST) ? '0 : kr + TAP_W'(1);
            end else begin
                kc_nxt = kc + TAP_W'(1);
            end
        end
        // Window position advances only once the result strobe has gone out
        if (state == S_WR) begin
            if (col == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (row == ROW_LAST) ? '0 : row + ADDR_W'(1);
            end else begin
                col_nxt = col + ADDR_W'(1);
            end
        end
        if (frz) begin
            kr_nxt  = kr;
            kc_nxt  = kc;
            row_nxt = row;
            col_nxt = col;
        end
        if (CLR) begin
            kr_nxt  = '0;
            kc_nxt  = '0;
            row_nxt = '0;
            col_nxt = '0;
        end
        pix_nxt = ADDR_W'((32'(row_nxt) + 32'(kr_nxt)) * IMG_W + 32'(col_nxt) + 32'(kc_nxt));
        tap_nxt = TAP_W'(32'(kr_nxt) * K + 32'(kc_nxt));
    end

    // Counters and registered outputs, loaded with the values of the upcoming cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kr        <= '0;
            kc        <= '0;
            row       <= '0;
            col       <= '0;
            pix_addr  <= '0;
            tap_idx   <= '0;
            acc_clr   <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            kr        <= kr_nxt;
            kc        <= kc_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            pix_addr  <= pix_nxt;
            tap_idx   <= tap_nxt;
            acc_clr   <= (state_nxt == S_CLRA);
            mac_en    <= (state_nxt == S_MAC);
            out_valid <= (state_nxt == S_WR);
            done      <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_IDLE);
        end
    end

    assign out_row = row;
    assign out_col = col;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: a run model pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_conv_window_sequencer;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int K      = 3;
    localparam int ADDR_W = 4;
    localparam int TAP_W  = 4;
    localparam int NR     = IMG_H - K + 1;
    localparam int NC     = IMG_W - K + 1;
    localparam int PER    = K * K + 2;
    localparam int FULL   = NR * NC * PER;

    localparam int K_CLRA = 0;
    localparam int K_MAC  = 1;
    localparam int K_WR   = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int t;
        int kind;
        int a;
        int b;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              CLR = 1'b0;
    logic              stall = 1'b0;
    logic              acc_clr, mac_en, out_valid, busy, done;
    logic [ADDR_W-1:0] pix_addr, out_row, out_col;
    logic [TAP_W-1:0]  tap_idx;

    int   total = 0;
    int   bad = 0;
    int   ecnt = 0;
    int   free_at = 1 << 30;
    exp_t q[$];

    conv_window_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ADDR_W(ADDR_W), .TAP_W(TAP_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .CLR(CLR),
`ifdef CONV_SEQ_STALL_EN
        .stall(stall),
`endif
        .acc_clr(acc_clr),
        .mac_en(mac_en),
        .pix_addr(pix_addr),
        .tap_idx(tap_idx),
        .out_valid(out_valid),
        .out_row(out_row),
        .out_col(out_col),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%0h want=%0h", name, ecnt, got, want);
        end
    endtask

    // Expected trace of one complete run whose start is sampled at edge e0
    task automatic push_run(input int e0);
        int t = e0;
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < NC; c++) begin
                q.push_back('{t, K_CLRA, 0, 0}); t++;
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        q.push_back('{t, K_MAC, (r + i) * IMG_W + c + j, i * K + j}); t++;
                    end
                end
                q.push_back('{t, K_WR, r, c}); t++;
            end
        end
        q.push_back('{t, K_DONE, 0, 0});
    endtask

    // Drive inputs for the next edge and let the model decide what that edge does
    task automatic step(input logic s, input logic c);
        int e;
        start = s;
        CLR = c;
        e = ecnt + 1;
        if (c) begin
            while (q.size() > 0 && q[$].t >= e) void'(q.pop_back());
            free_at = e + 1;
        end else if (s && e >= free_at) begin
            push_run(e);
            free_at = e + FULL + 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {27'd0, busy, done, out_valid, mac_en, acc_clr}, 32'd0);
        check({tag, "_pix"}, 32'(pix_addr), 32'd0);
        check({tag, "_tap"}, 32'(tap_idx), 32'd0);
        check({tag, "_rowcol"}, {16'(out_row), 16'(out_col)}, 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle, then release before the next edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        CLR = 1'b0;
        q.delete();
        free_at = 1 << 30;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        free_at = ecnt + 1;
    endtask

    // Monitor: every cycle the strobes must match the model, and addresses when valid
    exp_t        it;
    logic        have;
    logic [31:0] want_s, got_s;
    always @(negedge clk) begin
        have = 1'b0;
        want_s = 32'd0;
        if (q.size() > 0 && q[0].t == ecnt) begin
            it = q.pop_front();
            have = 1'b1;
            want_s = 32'd16 | (32'd1 << it.kind);
        end
        got_s = {27'd0, busy, done, out_valid, mac_en, acc_clr};
        check("strobes", got_s, want_s);
        if (have && it.kind == K_MAC) begin
            check("pix_addr", 32'(pix_addr), 32'(it.a));
            check("tap_idx", 32'(tap_idx), 32'(it.b));
        end
        if (have && it.kind == K_WR) begin
            check("out_row", 32'(out_row), 32'(it.a));
            check("out_col", 32'(out_col), 32'(it.b));
        end
    end

    initial begin
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        free_at = ecnt + 1;
        repeat (3) step(1'b0, 1'b0);

        // single run
        step(1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0);

        // start held high: back-to-back runs, none accepted while busy
        repeat (100) step(1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0);

        // abort during MAC of window 3, then a fresh run
        step(1'b1, 1'b0);
        repeat (2 * PER + 4) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0);

        // start and CLR together in IDLE
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0);

        // async reset mid-MAC
        step(1'b1, 1'b0);
        repeat (15) step(1'b0, 1'b0);
        do_reset();
        repeat (5) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (50) step(1'b0, 1'b0);

        // random start/CLR traffic
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 59) == 0));
        end

        // drain outstanding expectations within a bounded budget
        for (int n = 0; n < 4 * FULL && q.size() > 0; n++) step(1'b0, 1'b0);
        check("drain", 32'(q.size()), 32'd0);
        repeat (2) step(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
